// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the pe_mac_pool processing element:
//   - operating-mode encodings carried on the mode command field
//   - FSM state enumeration for the run sequencer
//   - default accumulator width with its signed range limits
//   - sat_add: signed add clamped to a caller-supplied accumulator width
// -----------------------------------------------------------------------------
package pe_pkg;

  localparam logic [1:0] MODE_MAC     = 2'b00;
  localparam logic [1:0] MODE_MAXPOOL = 2'b01;
  localparam logic [1:0] MODE_SUMPOOL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int ACC_W = 40;
  localparam logic signed [63:0] ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
  localparam logic signed [63:0] ACC_MIN = -(64'sd1 <<< (ACC_W - 1));

  // Operands are sign-extended 64-bit views of w-bit values (w <= 63).
  // The sum is formed one bit wider so it can never wrap before the clamp.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        w
  );
    logic signed [64:0] sum;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sum = 65'(a) + 65'(b);
    hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (w - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return 64'(sum);
  endfunction

endpackage

// File: rtl/pe_local_store.sv
// -----------------------------------------------------------------------------
// pe_local_store
// 2^A x W single-port-write / single-port-read local store.
// Synchronous write, synchronous read with one cycle of latency. A read and a
// write to the same address in one cycle return the previous contents.
// Contents have no reset.
// Ports:
//   CLK    in  1  clock
//   we     in  1  write enable
//   waddr  in  A  write address
//   wdata  in  W  write data
//   raddr  in  A  read address (sampled every cycle)
//   rdata  out W  registered read data
// -----------------------------------------------------------------------------
module pe_local_store
  import pe_pkg::*;
#(
  parameter int W = 16,
  parameter int A = 7
) (
  input  logic         CLK,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [A-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [2**A];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pe_mac_pool.sv
// -----------------------------------------------------------------------------
// pe_mac_pool
// CNN-array processing element. Owns a kernel store and a neuron store, walks
// both from programmable base addresses (wrapping modulo 2^A) and folds N terms
// into a saturating ACC_W-bit accumulator in one of three modes:
//   MAC      acc = sat(acc + k*n), seeded with acc_in
//   max-pool acc = max(acc, n),     seeded with the most-negative value
//   sum-pool acc = sat(acc + n),    seeded with acc_in
// The result is offered on a valid/ready handshake; out_valid rises N+3 clock
// edges after the edge that accepted start.
// Ports:
//   CLK, RST_N                     clock, asynchronous active-low reset
//   kernel_we/waddr/wdata          kernel store write port
//   neuron_we/waddr/wdata          neuron store write port
//   start                          command strobe, honoured only when idle
//   mode, base_k, base_n, len      command fields latched with start
//   acc_in                         upstream partial sum latched with start
//   busy                           command in flight until result taken
//   out_valid, out_ready, out_data result handshake
// -----------------------------------------------------------------------------
module pe_mac_pool #(
  parameter int W     = 16,
  parameter int A     = 7,
  parameter int ACC_W = 40
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    kernel_we,
  input  logic [A-1:0]            kernel_waddr,
  input  logic [W-1:0]            kernel_wdata,
  input  logic                    neuron_we,
  input  logic [A-1:0]            neuron_waddr,
  input  logic [W-1:0]            neuron_wdata,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [A-1:0]            base_k,
  input  logic [A-1:0]            base_n,
  input  logic [A:0]              len,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data
);

  import pe_pkg::*;

  localparam logic signed [ACC_W-1:0] ACC_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  function automatic logic signed [2*W-1:0] term_of(
    input logic [1:0]          m,
    input logic signed [W-1:0] k,
    input logic signed [W-1:0] n
  );
    if (m == MODE_MAXPOOL || m == MODE_SUMPOOL) begin
      return (2*W)'(n);
    end
    return (2*W)'(k) * (2*W)'(n);
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_step(
    input logic [1:0]              m,
    input logic signed [ACC_W-1:0] a,
    input logic signed [2*W-1:0]   t
  );
    logic signed [ACC_W-1:0] t_ext;
    t_ext = ACC_W'(t);
    if (m == MODE_MAXPOOL) begin
      return (t_ext > a) ? t_ext : a;
    end
    return ACC_W'(sat_add(64'(a), 64'(t_ext), ACC_W));
  endfunction

  state_t                  state;
  state_t                  state_nxt;
  logic [1:0]              mode_q;
  logic [A-1:0]            base_k_q;
  logic [A-1:0]            base_n_q;
  logic [A:0]              len_q;
  logic [A:0]              cnt;
  logic                    accept;
  logic                    last_issue;
  logic                    drain_seen;

  logic                    vld_p0;
  logic [A-1:0]            raddr_k_p0;
  logic [A-1:0]            raddr_n_p0;
  logic                    vld_p1;
  logic [W-1:0]            kdata_p1;
  logic [W-1:0]            ndata_p1;
  logic                    vld_p2;
  logic signed [2*W-1:0]   prod_p2;
  logic signed [ACC_W-1:0] acc;

  assign accept     = (state == S_IDLE) && start;
  assign last_issue = (len_q == '0) || (cnt == len_q - (A+1)'(1));
  assign busy       = (state != S_IDLE);
  assign out_valid  = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_issue) state_nxt = S_DRAIN;
      // The extra DRAIN cycle keeps N=0 on the same N+3 schedule as N>0.
      S_DRAIN: if (drain_seen && !vld_p1 && !vld_p2) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: address issue
  assign vld_p0     = (state == S_RUN) && (cnt != len_q);
  assign raddr_k_p0 = base_k_q + cnt[A-1:0];
  assign raddr_n_p0 = base_n_q + cnt[A-1:0];

  // Stage p1: store read
  pe_local_store #(.W(W), .A(A)) u_kernel_store (
    .CLK   (CLK),
    .we    (kernel_we),
    .waddr (kernel_waddr),
    .wdata (kernel_wdata),
    .raddr (raddr_k_p0),
    .rdata (kdata_p1)
  );

  pe_local_store #(.W(W), .A(A)) u_neuron_store (
    .CLK   (CLK),
    .we    (neuron_we),
    .waddr (neuron_waddr),
    .wdata (neuron_wdata),
    .raddr (raddr_n_p0),
    .rdata (ndata_p1)
  );

  // Stage p2: product register
  always_ff @(posedge CLK) begin
    if (accept) begin
      mode_q   <= mode;
      base_k_q <= base_k;
      base_n_q <= base_n;
      len_q    <= len;
    end
    prod_p2 <= term_of(mode_q, kdata_p1, ndata_p1);
  end

  // Stage p3: accumulate, result capture
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      cnt        <= '0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      drain_seen <= 1'b0;
      acc        <= '0;
      out_data   <= '0;
    end else begin
      state      <= state_nxt;
      vld_p1     <= vld_p0;
      vld_p2     <= vld_p1;
      drain_seen <= (state == S_DRAIN);
      if (accept) begin
        cnt <= '0;
      end else if (vld_p0) begin
        cnt <= cnt + (A+1)'(1);
      end
      if (accept) begin
        acc <= (mode == MODE_MAXPOOL) ? ACC_NEG : acc_in;
      end else if (vld_p2) begin
        acc <= acc_step(mode_q, acc, prod_p2);
      end
      if (state == S_DRAIN && state_nxt == S_DONE) begin
        out_data <= acc;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_pool.sv
// -----------------------------------------------------------------------------
// tb_pe_mac_pool
// Directed bench for pe_mac_pool. Each command pushes its hand-computed result
// onto a queue; a negedge monitor pops and compares on every handshake. The
// stimulus thread checks latency, busy, hold stability and reset behaviour.
// -----------------------------------------------------------------------------
module tb_pe_mac_pool;

  localparam int W     = 16;
  localparam int A     = 7;
  localparam int ACC_W = 40;

  localparam logic [1:0] M_MAC = 2'b00;
  localparam logic [1:0] M_MAX = 2'b01;
  localparam logic [1:0] M_SUM = 2'b10;
  localparam logic [1:0] M_RSV = 2'b11;

  localparam logic signed [ACC_W-1:0] SAT_MAX   = 40'sh7F_FFFF_FFFF;
  localparam logic signed [ACC_W-1:0] SAT_START = 40'sh7F_FFFF_FFF6;
  localparam logic signed [ACC_W-1:0] ACC_NEG   = 40'sh80_0000_0000;

  logic                    CLK = 1'b0;
  logic                    RST_N;
  logic                    kernel_we;
  logic [A-1:0]            kernel_waddr;
  logic [W-1:0]            kernel_wdata;
  logic                    neuron_we;
  logic [A-1:0]            neuron_waddr;
  logic [W-1:0]            neuron_wdata;
  logic                    start;
  logic [1:0]              mode;
  logic [A-1:0]            base_k;
  logic [A-1:0]            base_n;
  logic [A:0]              len;
  logic signed [ACC_W-1:0] acc_in;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;

  int vectors     = 0;
  int miscompares = 0;
  logic signed [ACC_W-1:0] exp_q[$];
  logic signed [ACC_W-1:0] mon_exp;

  always #5 CLK = ~CLK;

  pe_mac_pool #(.W(W), .A(A), .ACC_W(ACC_W)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .kernel_we    (kernel_we),
    .kernel_waddr (kernel_waddr),
    .kernel_wdata (kernel_wdata),
    .neuron_we    (neuron_we),
    .neuron_waddr (neuron_waddr),
    .neuron_wdata (neuron_wdata),
    .start        (start),
    .mode         (mode),
    .base_k       (base_k),
    .base_n       (base_n),
    .len          (len),
    .acc_in       (acc_in),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_result: got %0d, expected no result", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          miscompares++;
          $display("FAIL result_data: got %0d, expected %0d", out_data, mon_exp);
        end
      end
    end
  end

  task automatic wr_k(input int addr, input int data);
    @(negedge CLK);
    kernel_we    = 1'b1;
    kernel_waddr = A'(addr);
    kernel_wdata = W'(data);
    @(posedge CLK);
    #1 kernel_we = 1'b0;
  endtask

  task automatic wr_n(input int addr, input int data);
    @(negedge CLK);
    neuron_we    = 1'b1;
    neuron_waddr = A'(addr);
    neuron_wdata = W'(data);
    @(posedge CLK);
    #1 neuron_we = 1'b0;
  endtask

  // Returns 1 ns after the edge that samples start.
  task automatic start_cmd(input logic [1:0] m, input int bk, input int bn,
                           input int ln, input logic signed [ACC_W-1:0] ai,
                           input bit push, input logic signed [ACC_W-1:0] exp);
    @(negedge CLK);
    start  = 1'b1;
    mode   = m;
    base_k = A'(bk);
    base_n = A'(bn);
    len    = (A+1)'(ln);
    acc_in = ai;
    if (push) exp_q.push_back(exp);
    @(posedge CLK);
    #1 start = 1'b0;
    check("busy_after_start", 64'(busy), 64'sd1);
  endtask

  task automatic wait_valid(input string name, input int elapsed, input int lat);
    int got;
    got = -1;
    for (int k = elapsed + 1; k <= 300; k++) begin
      @(posedge CLK);
      #1;
      if (out_valid) begin
        got = k;
        break;
      end
    end
    check({name, "_latency"}, 64'(got), 64'(lat));
  endtask

  task automatic handshake_done(input string name);
    @(posedge CLK);
    #1;
    check({name, "_idle_after_hs"}, 64'({busy, out_valid}), 64'sd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int mp_vals[10];
    mp_vals = '{-3, 9, -20, 4, 9, 0, -1, 2, -7, 11};

    RST_N = 1'b0; kernel_we = 1'b0; kernel_waddr = '0; kernel_wdata = '0;
    neuron_we = 1'b0; neuron_waddr = '0; neuron_wdata = '0;
    start = 1'b0; mode = '0; base_k = '0; base_n = '0; len = '0;
    acc_in = '0; out_ready = 1'b1;

    repeat (2) @(posedge CLK);
    #1;
    check("reset_busy", 64'(busy), 64'sd0);
    check("reset_out_valid", 64'(out_valid), 64'sd0);
    check("reset_out_data", 64'(out_data), 64'sd0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 4; i++) wr_k(i, i + 1);
    for (int i = 0; i < 4; i++) wr_n(10 + i, 5 + i);

    start_cmd(M_MAC, 0, 10, 4, 40'sd100, 1'b1, 40'sd170);
    wait_valid("mac4", 0, 7);
    handshake_done("mac4");

    start_cmd(M_RSV, 0, 10, 4, 40'sd100, 1'b1, 40'sd170);
    wait_valid("reserved_mode", 0, 7);
    handshake_done("reserved_mode");

    for (int i = 0; i < 10; i++) wr_n((120 + i) % 128, mp_vals[i]);
    start_cmd(M_MAX, 0, 120, 10, 40'sd50, 1'b1, 40'sd11);
    wait_valid("maxpool_wrap", 0, 13);
    handshake_done("maxpool_wrap");

    start_cmd(M_MAC, 0, 0, 0, -40'sd42, 1'b1, -40'sd42);
    wait_valid("mac_len0", 0, 3);
    handshake_done("mac_len0");

    start_cmd(M_MAX, 0, 0, 0, 40'sd5, 1'b1, ACC_NEG);
    wait_valid("max_len0", 0, 3);
    handshake_done("max_len0");

    wr_k(20, 32767); wr_k(21, 32767);
    wr_n(20, 32767); wr_n(21, 32767);
    out_ready = 1'b0;
    start_cmd(M_MAC, 20, 20, 2, SAT_START, 1'b1, SAT_MAX);
    wait_valid("sat", 0, 5);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        @(negedge CLK);
        start = 1'b1; mode = M_MAC; base_k = '0; base_n = 7'd10;
        len = 8'd1; acc_in = '0;
      end
      @(posedge CLK);
      #1 start = 1'b0;
      check("hold_data", 64'(out_data), 64'(SAT_MAX));
      check("hold_valid_busy", 64'({out_valid, busy}), 64'sd3);
    end
    out_ready = 1'b1;
    handshake_done("sat");
    repeat (6) @(posedge CLK);
    #1;
    check("ignored_start", 64'({busy, out_valid}), 64'sd0);

    start_cmd(M_MAC, 0, 0, 20, 40'sd0, 1'b0, 40'sd0);
    repeat (5) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("midrun_reset_busy", 64'(busy), 64'sd0);
    check("midrun_reset_valid", 64'(out_valid), 64'sd0);
    check("midrun_reset_data", 64'(out_data), 64'sd0);
    @(negedge CLK);
    RST_N = 1'b1;
    start_cmd(M_MAC, 0, 10, 4, 40'sd100, 1'b1, 40'sd170);
    wait_valid("after_reset", 0, 7);
    handshake_done("after_reset");

    for (int i = 0; i < 3; i++) wr_n(40 + i, -1);
    start_cmd(M_SUM, 0, 40, 3, 40'sd5, 1'b1, 40'sd2);
    neuron_we = 1'b1; neuron_waddr = 7'd40; neuron_wdata = 16'd100;
    @(posedge CLK);
    #1 neuron_waddr = 7'd41;
    @(posedge CLK);
    #1 neuron_waddr = 7'd42;
    @(posedge CLK);
    #1 neuron_we = 1'b0;
    wait_valid("sum_read_first", 3, 6);
    handshake_done("sum_read_first");

    start_cmd(M_SUM, 0, 40, 3, 40'sd5, 1'b1, 40'sd305);
    wait_valid("sum_after_write", 0, 6);
    handshake_done("sum_after_write");

    repeat (3) @(posedge CLK);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'sd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
